seq_detect_sched: RTL and testbench
===================================

# seq_detect_sched

Round-robin scheduler that shares one serial "111" sequence detector among N_REQ requesters. Each requester presents a WORD_W-bit word. The block grants one requester at a time, captures its word, and shifts the word LSB-first through the detector. It then reports how many overlapping "111" runs occurred. It is the control layer above the bit-serial detector FSMs, so several clients can use one detector without a per-client FSM.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- WORD_W, default 8: bits per request word (3..16).
- CNT_W, default 4: width of match_cnt; must hold WORD_W-2.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high. Forces every register and output to its reset value immediately.
- req  in  N_REQ  per-requester request level.
- data  in  N_REQ*WORD_W  flattened words; requester i owns bits [i*WORD_W +: WORD_W].
- gnt  out  N_REQ  one-hot grant, held for the whole transaction; reset 0.
- busy  out  1  high in SHIFT and REPORT; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- done_id  out  clog2(N_REQ)  index of the completed requester; reset 0.
- match_cnt  out  CNT_W  number of "111" occurrences in the completed word; reset 0.
- found  out  1  match_cnt != 0 for the completed word; reset 0.

## Operation
- States: IDLE, SHIFT, REPORT.
- IDLE:
  - If any req bit is set, pick the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Set gnt to that one-hot and capture data of that requester into the shift register.
  - Clear run length (0..2), bit counter and internal count, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per cycle, LSB first:
  - bit=1 with run==2: count += 1, run stays 2 (overlapping detection).
  - bit=1 with run<2: run += 1.
  - bit=0: run = 0.
  - After the WORD_W-th bit, go to REPORT.
- REPORT:
  - done=1; done_id, match_cnt and found take the final values.
  - ptr = granted index + 1 mod N_REQ.
  - gnt drops, then go to IDLE.
- Definition: match_cnt is the number of positions i in 2..WORD_W-1 where word[i-2], word[i-1] and word[i] are all 1.
- Hold rules:
  - done_id, match_cnt and found hold their values until the next REPORT.
  - done is high only in REPORT.
- Request handshake:
  - req is a level. Data is sampled only at the grant edge, so later changes to req or data do not affect the transaction.
  - A requester that keeps req high after done is not regranted ahead of other pending requesters, because ptr has advanced past it.
- At most one gnt bit is ever set. gnt==0 in IDLE.
- ptr resets to 0.

## Timing
- Edge E0: in IDLE with req != 0. gnt and busy go high after E0.
- Edges E1..E{WORD_W}: consume bits 0..WORD_W-1.
- After edge E{WORD_W}: state REPORT, done=1 for exactly one cycle.
- After edge E{WORD_W+1}: back in IDLE, gnt=0, busy=0. The earliest next grant is at edge E{WORD_W+2}.
- Transaction period is WORD_W+2 cycles. done rises WORD_W cycles after gnt rises.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs 0 and ptr=0.
  - The aborted transaction produces no done.
  - After release, the first edge with req set grants normally.
- req dropping during SHIFT: the transaction still completes and reports.
- New req arriving during SHIFT or REPORT: waits; it is arbitrated in IDLE.

## Test plan
- Single requester 0, data=8'h07, WORD_W=8 -> gnt=4'b0001 for 9 cycles, done pulse 8 cycles after gnt rise, match_cnt=1, found=1, done_id=0.
- Requester 1, data=8'hFF -> match_cnt=6, found=1, done_id=1.
- Requester 2, data=8'h6D -> match_cnt=0, found=0. Then requester 3, data=8'h3B -> match_cnt=1.
- req=4'b1111 held from reset release -> grant order 0,1,2,3,0, one grant every 10 cycles, never two gnt bits set.
- req=4'b0001 at grant edge, then req switches to 4'b0000 and data changes during SHIFT -> result reflects the captured word; done still pulses.
- Reset asserted 3 cycles into SHIFT -> gnt, busy, done, match_cnt, found and done_id all 0 immediately. No done follows. After release with req=4'b0100, grant goes to index 2.

Source files
------------

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin scheduler sharing one serial "111" detector
//   among N_REQ requesters. A granted word is shifted LSB-first and the
//   number of overlapping "111" runs is reported with a one-cycle done pulse.
// Ports: clk, reset (async, active-high); req[N_REQ] request levels;
//   data[N_REQ*WORD_W] flattened words (requester i owns [i*WORD_W +: WORD_W]);
//   gnt one-hot grant; busy (SHIFT/REPORT); done pulse; done_id, match_cnt,
//   found hold the last completed result until the next report.
module seq_detect_sched #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    found
);

  localparam int BCW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [IDW-1:0]      ptr_q,       ptr_d;
  logic [IDW-1:0]      gnt_idx_q,   gnt_idx_d;
  logic [N_REQ-1:0]    gnt_q,       gnt_d;
  logic [WORD_W-1:0]   sreg_q,      sreg_d;
  logic [1:0]          run_q,       run_d;
  logic [BCW-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [IDW-1:0]      done_id_q,   done_id_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic                found_q,     found_d;

  // Rotating priority search: first set req bit at ptr, ptr+1, ... mod N_REQ.
  logic           sel_hit;
  logic [IDW-1:0] sel_idx;

  always_comb begin
    int idx;
    sel_hit = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!sel_hit && req[idx]) begin
        sel_hit = 1'b1;
        sel_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_d       = gnt_q;
    sreg_d      = sreg_q;
    run_d       = run_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    found_d     = found_q;

    case (state_q)
      IDLE: begin
        if (sel_hit) begin
          // The word is sampled only here; later req/data changes are ignored.
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          gnt_idx_d      = sel_idx;
          sreg_d         = data[int'(sel_idx)*WORD_W +: WORD_W];
          run_d          = 2'd0;
          bit_cnt_d      = '0;
          cnt_d          = '0;
          state_d        = SHIFT;
        end
      end

      SHIFT: begin
        sreg_d    = sreg_q >> 1;
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (sreg_q[0]) begin
          // Run saturates at 2 so every further 1 counts (overlapping matches).
          if (run_q == 2'd2) cnt_d = cnt_q + CNT_W'(1);
          else               run_d = run_q + 2'd1;
        end else begin
          run_d = 2'd0;
        end
        if (bit_cnt_q == BCW'(WORD_W - 1)) begin
          // Latch the result on the last bit so it is visible throughout REPORT.
          state_d     = REPORT;
          done_id_d   = gnt_idx_q;
          match_cnt_d = cnt_d;
          found_d     = (cnt_d != '0);
        end
      end

      REPORT: begin
        gnt_d   = '0;
        ptr_d   = (int'(gnt_idx_q) == N_REQ - 1) ? '0 : gnt_idx_q + IDW'(1);
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_q       <= '0;
      sreg_q      <= '0;
      run_q       <= 2'd0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_q       <= gnt_d;
      sreg_q      <= sreg_d;
      run_q       <= run_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      found_q     <= found_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == REPORT);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign found     = found_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: directed bench for seq_detect_sched (N_REQ=4, WORD_W=8).
//   Inputs change on negedge; outputs are sampled on negedge.
//   Expected values are hand-computed constants.
module tb_seq_detect_sched;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*WORD_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic                    busy;
  logic                    done;
  logic [1:0]              done_id;
  logic [CNT_W-1:0]        match_cnt;
  logic                    found;

  int n_chk  = 0;
  int n_pass = 0;

  seq_detect_sched #(.N_REQ(N_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .found     (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One transaction from IDLE: req raised at a negedge, dropped (and data
  // scrambled) right after the grant, then observed for 12 cycles.
  task automatic run_txn(input int idx, input logic [7:0] word, input int exp_cnt);
    int gnt_cycles;
    int done_cycles;
    int done_at;
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << idx;
    data[idx*WORD_W +: WORD_W] = word;
    req = exp_gnt;
    @(negedge clk);
    chk($sformatf("grant%0d_gnt", idx), gnt, exp_gnt);
    chk($sformatf("grant%0d_busy", idx), busy, 1);
    req = '0;
    data[idx*WORD_W +: WORD_W] = ~word;
    gnt_cycles  = 1;
    done_cycles = 0;
    done_at     = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (gnt == exp_gnt) gnt_cycles++;
      if (done) begin
        done_cycles++;
        done_at = k;
        chk($sformatf("txn%0d_done_id", idx), done_id, idx);
        chk($sformatf("txn%0d_match_cnt", idx), match_cnt, exp_cnt);
        chk($sformatf("txn%0d_found", idx), found, (exp_cnt != 0));
      end
      if (k == 10) begin
        chk($sformatf("txn%0d_idle_gnt", idx), gnt, 0);
        chk($sformatf("txn%0d_idle_busy", idx), busy, 0);
      end
    end
    chk($sformatf("txn%0d_gnt_cycles", idx), gnt_cycles, 9);
    chk($sformatf("txn%0d_done_latency", idx), done_at, 8);
    chk($sformatf("txn%0d_done_pulses", idx), done_cycles, 1);
    chk($sformatf("txn%0d_hold_cnt", idx), match_cnt, exp_cnt);
  endtask

  initial begin
    int grant_ids[$];
    int grant_at[$];
    int multi;
    int dn;
    logic [3:0] prev_gnt;

    reset = 1'b1;
    req   = '0;
    data  = '0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_found", found, 0);
    @(negedge clk);
    reset = 1'b0;

    // Word results: 07 -> 1, FF -> 6, 6D -> 0, 3B -> 1.
    run_txn(0, 8'h07, 1);
    run_txn(1, 8'hFF, 6);
    run_txn(2, 8'h6D, 0);
    run_txn(3, 8'h3B, 1);

    // Reset three cycles into SHIFT: everything clears at once, no done.
    req = 4'b0001;
    data[0 +: 8] = 8'hFF;
    @(negedge clk);
    chk("abort_grant", gnt, 4'b0001);
    req = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_done_id", done_id, 0);
    chk("abort_match_cnt", match_cnt, 0);
    chk("abort_found", found, 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    req = 4'b0100;
    @(negedge clk);
    chk("post_abort_gnt", gnt, 4'b0100);
    req = '0;
    repeat (12) @(negedge clk);

    // All four requesting from reset release: 0,1,2,3,0 every 10 cycles.
    reset = 1'b1;
    req   = 4'b1111;
    @(negedge clk);
    reset    = 1'b0;
    multi    = 0;
    prev_gnt = '0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if ((gnt & (gnt - 4'd1)) != 4'd0) multi++;
      if (prev_gnt == 4'd0 && gnt != 4'd0) begin
        for (int b = 0; b < N_REQ; b++)
          if (gnt[b]) grant_ids.push_back(b);
        grant_at.push_back(k);
      end
      prev_gnt = gnt;
    end
    req = '0;
    chk("rr_multi_gnt", multi, 0);
    chk("rr_grant_count", grant_ids.size(), 5);
    for (int i = 0; i < 5 && i < grant_ids.size(); i++)
      chk($sformatf("rr_order%0d", i), grant_ids[i], i % N_REQ);
    for (int i = 1; i < 5 && i < grant_at.size(); i++)
      chk($sformatf("rr_spacing%0d", i), grant_at[i] - grant_at[i-1], 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
